// File: rtl/mem_unit.sv
// Main-store controller: strobe-driven CPU port plus idle-time loader port,
// serialized through a single IDLE/WAIT/ACCESS sequencer.
module mem_unit #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 31,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_read_pulse,
    input  logic              mem_write_pulse,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_reply,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_busy,
    output logic              mem_err,
    input  logic              err_clr,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_write,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam int         DEPTH     = 1 << ADDR_W;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              op_wr_q, op_wr_d;
    logic              own_ld_q, own_ld_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic cpu_req;
    logic capture;
    logic ld_ready_c;
    logic rd_en;
    logic err_set;

    assign cpu_req = mem_read_pulse | mem_write_pulse;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_wr_d    = op_wr_q;
        own_ld_d   = own_ld_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        capture    = 1'b0;
        ld_ready_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ld_ready_c = ~cpu_req;
                // A simultaneous read+write strobe is treated as the write.
                if (cpu_req) begin
                    capture  = 1'b1;
                    op_wr_d  = mem_write_pulse;
                    own_ld_d = 1'b0;
                    addr_d   = mem_addr;
                    wdata_d  = mem_wdata;
                end else if (ld_valid) begin
                    capture  = 1'b1;
                    op_wr_d  = ld_write;
                    own_ld_d = 1'b1;
                    addr_d   = ld_addr;
                    wdata_d  = ld_wdata;
                end
                if (capture) begin
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Read data is fetched on the edge entering ACCESS so it is
    // already registered when the reply strobe rises.
    assign rd_en   = (state_d == S_ACCESS) && !op_wr_d;
    assign err_set = cpu_req &&
                     ((state_q != S_IDLE) || (mem_read_pulse && mem_write_pulse));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            op_wr_q   <= 1'b0;
            own_ld_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_rdata <= '0;
            ld_rdata  <= '0;
            mem_err   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_wr_q  <= op_wr_d;
            own_ld_q <= own_ld_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            if (rd_en && !own_ld_d)
                mem_rdata <= mem[addr_d];
            if (rd_en && own_ld_d)
                ld_rdata <= mem[addr_d];
            if (err_set)
                mem_err <= 1'b1;
            else if (err_clr)
                mem_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && (state_q == S_ACCESS) && op_wr_q)
            mem[addr_q] <= wdata_q;
    end

    assign mem_reply = resetn && (state_q == S_ACCESS) && !own_ld_q;
    assign ld_rvalid = resetn && (state_q == S_ACCESS) && own_ld_q && !op_wr_q;
    assign mem_busy  = (state_q != S_IDLE);
    assign ld_ready  = resetn && ld_ready_c;

endmodule

// File: tb/tb_mem_unit.sv
// Bench for mem_unit: WAIT_CYCLES=2 instance for protocol/loader checks,
// WAIT_CYCLES=0 instance for back-to-back latency.
module tb_mem_unit;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        rd_p [2];
    logic        wr_p [2];
    logic        err_clr [2];
    logic [9:0]  addr [2];
    logic [30:0] wdata [2];
    logic        reply [2];
    logic        busy [2];
    logic        err [2];
    logic [30:0] rdata [2];
    logic        ld_valid [2];
    logic        ld_ready [2];
    logic        ld_write [2];
    logic        ld_rvalid [2];
    logic [9:0]  ld_addr [2];
    logic [30:0] ld_wdata [2];
    logic [30:0] ld_rdata [2];

    mem_unit #(.ADDR_W(10), .DATA_W(31), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .resetn(resetn),
        .mem_read_pulse(rd_p[0]), .mem_write_pulse(wr_p[0]),
        .mem_addr(addr[0]), .mem_wdata(wdata[0]),
        .mem_reply(reply[0]), .mem_rdata(rdata[0]),
        .mem_busy(busy[0]), .mem_err(err[0]), .err_clr(err_clr[0]),
        .ld_valid(ld_valid[0]), .ld_ready(ld_ready[0]),
        .ld_write(ld_write[0]), .ld_addr(ld_addr[0]),
        .ld_wdata(ld_wdata[0]), .ld_rvalid(ld_rvalid[0]),
        .ld_rdata(ld_rdata[0])
    );

    mem_unit #(.ADDR_W(10), .DATA_W(31), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .resetn(resetn),
        .mem_read_pulse(rd_p[1]), .mem_write_pulse(wr_p[1]),
        .mem_addr(addr[1]), .mem_wdata(wdata[1]),
        .mem_reply(reply[1]), .mem_rdata(rdata[1]),
        .mem_busy(busy[1]), .mem_err(err[1]), .err_clr(err_clr[1]),
        .ld_valid(ld_valid[1]), .ld_ready(ld_ready[1]),
        .ld_write(ld_write[1]), .ld_addr(ld_addr[1]),
        .ld_wdata(ld_wdata[1]), .ld_rvalid(ld_rvalid[1]),
        .ld_rdata(ld_rdata[1])
    );

    int n_run = 0;
    int n_fail = 0;

    // Reference: word store per instance plus last CPU read value.
    logic [30:0] ref_mem0 [1024];
    logic [30:0] ref_mem1 [1024];
    logic [30:0] last_rd [2];
    logic [9:0]  written [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one CPU strobe cycle, then watch up to win cycles for replies.
    task automatic cpu_access(input int k, input bit rd, input bit wr,
                              input logic [9:0] a, input logic [30:0] d,
                              input int win, input bit early,
                              output int lat, output int nrep,
                              output logic [30:0] r);
        rd_p[k] = rd;
        wr_p[k] = wr;
        addr[k] = a;
        wdata[k] = d;
        tick();
        rd_p[k] = 1'b0;
        wr_p[k] = 1'b0;
        lat = -1;
        nrep = 0;
        r = '0;
        for (int i = 1; i <= win; i++) begin
            #1;
            if (reply[k]) begin
                nrep++;
                if (lat < 0) begin
                    lat = i;
                    r = rdata[k];
                end
            end
            tick();
            if (early && lat >= 0) break;
        end
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rd_p[k] = 0; wr_p[k] = 0; err_clr[k] = 0;
            addr[k] = '0; wdata[k] = '0;
            ld_valid[k] = 0; ld_write[k] = 0;
            ld_addr[k] = '0; ld_wdata[k] = '0;
            last_rd[k] = '0;
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_run++;
            if ({reply[k], busy[k], err[k], ld_ready[k], ld_rvalid[k]} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_flags[%0d]: got %b want 00000", k,
                         {reply[k], busy[k], err[k], ld_ready[k], ld_rvalid[k]});
            end
            n_run++;
            if (rdata[k] !== 31'd0 || ld_rdata[k] !== 31'd0) begin
                n_fail++;
                $display("FAIL reset_data[%0d]: got %h/%h want 0/0", k, rdata[k], ld_rdata[k]);
            end
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        int lat, nrep;
        logic [30:0] r;
        cpu_access(0, 0, 1, 10'h005, 31'h2AAAAAAA, 6, 0, lat, nrep, r);
        ref_mem0[5] = 31'h2AAAAAAA;
        written.push_back(10'h005);
        n_run++;
        if (lat !== 3 || nrep !== 1) begin
            n_fail++;
            $display("FAIL wr_latency: got lat=%0d n=%0d want lat=3 n=1", lat, nrep);
        end
        n_run++;
        if (rdata[0] !== last_rd[0]) begin
            n_fail++;
            $display("FAIL wr_rdata_hold: got %h want %h", rdata[0], last_rd[0]);
        end
        cpu_access(0, 1, 0, 10'h005, 31'h0, 6, 0, lat, nrep, r);
        last_rd[0] = ref_mem0[5];
        n_run++;
        if (lat !== 3 || nrep !== 1 || r !== 31'h2AAAAAAA) begin
            n_fail++;
            $display("FAIL rd_basic: got lat=%0d n=%0d d=%h want 3 1 2aaaaaaa", lat, nrep, r);
        end
    endtask

    task automatic test_random();
        int lat, nrep;
        logic [30:0] r, d;
        logic [9:0] a;
        bit do_wr;
        for (int n = 0; n < 24; n++) begin
            do_wr = ($urandom_range(0, 1) == 1) || (n < 4);
            if (do_wr) begin
                a = 10'($urandom_range(0, 1023));
                d = 31'($urandom);
                cpu_access(0, 0, 1, a, d, 6, 0, lat, nrep, r);
                ref_mem0[a] = d;
                written.push_back(a);
                n_run++;
                if (lat !== 3 || nrep !== 1 || rdata[0] !== last_rd[0]) begin
                    n_fail++;
                    $display("FAIL rand_wr @%h: got lat=%0d n=%0d rd=%h want 3 1 %h",
                             a, lat, nrep, rdata[0], last_rd[0]);
                end
            end else begin
                a = written[$urandom_range(0, written.size() - 1)];
                cpu_access(0, 1, 0, a, 31'($urandom), 6, 0, lat, nrep, r);
                last_rd[0] = ref_mem0[a];
                n_run++;
                if (lat !== 3 || nrep !== 1 || r !== ref_mem0[a]) begin
                    n_fail++;
                    $display("FAIL rand_rd @%h: got lat=%0d n=%0d d=%h want 3 1 %h",
                             a, lat, nrep, r, ref_mem0[a]);
                end
            end
        end
        n_run++;
        if (err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_err: got %b want 0", err[0]);
        end
    endtask

    task automatic test_busy_err();
        int nrep = 0;
        int rep_i = -1;
        for (int i = 0; i < 8; i++) begin
            rd_p[0] = (i < 2);
            err_clr[0] = (i == 1) || (i == 5);
            addr[0] = 10'h005;
            #1;
            if (reply[0]) begin
                nrep++;
                rep_i = i;
            end
            if (i >= 1 && i <= 3) begin
                n_run++;
                if (busy[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_flag c%0d: got %b want 1", i, busy[0]);
                end
            end
            if (i == 2 || i == 5) begin
                n_run++;
                if (err[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_err_set c%0d: got %b want 1", i, err[0]);
                end
            end
            if (i == 6) begin
                n_run++;
                if (err[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL err_clr: got %b want 0", err[0]);
                end
            end
            tick();
        end
        rd_p[0] = 0;
        err_clr[0] = 0;
        last_rd[0] = ref_mem0[5];
        n_run++;
        if (nrep !== 1 || rep_i !== 3 || rdata[0] !== ref_mem0[5]) begin
            n_fail++;
            $display("FAIL busy_reply: got n=%0d at=%0d d=%h want 1 3 %h",
                     nrep, rep_i, rdata[0], ref_mem0[5]);
        end
    endtask

    task automatic test_rw_collision();
        int lat, nrep;
        logic [30:0] r;
        logic [30:0] prev;
        prev = last_rd[0];
        cpu_access(0, 1, 1, 10'h3FF, 31'h1, 6, 0, lat, nrep, r);
        ref_mem0[1023] = 31'h1;
        written.push_back(10'h3FF);
        n_run++;
        if (lat !== 3 || nrep !== 1 || err[0] !== 1'b1 || rdata[0] !== prev) begin
            n_fail++;
            $display("FAIL rw_collide: got lat=%0d n=%0d err=%b rd=%h want 3 1 1 %h",
                     lat, nrep, err[0], rdata[0], prev);
        end
        err_clr[0] = 1;
        tick();
        err_clr[0] = 0;
        cpu_access(0, 1, 0, 10'h3FF, 31'h0, 6, 0, lat, nrep, r);
        last_rd[0] = 31'h1;
        n_run++;
        if (r !== 31'h1 || lat !== 3 || err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_readback: got d=%h lat=%0d err=%b want 1 3 0", r, lat, err[0]);
        end
    endtask

    task automatic test_loader();
        logic [9:0] b;
        logic [30:0] x;
        logic [30:0] rv_d = '0;
        int nrep = 0;
        int rep_i = -1;
        int acc_i = -1;
        int rv_i = -1;
        int nrv = 0;
        b = 10'($urandom_range(32, 1000));
        x = 31'($urandom);
        rd_p[0] = 1;
        addr[0] = 10'h005;
        ld_valid[0] = 1;
        ld_write[0] = 1;
        ld_addr[0] = b;
        ld_wdata[0] = x;
        #1;
        n_run++;
        if (ld_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ld_prio: got ready=%b want 0", ld_ready[0]);
        end
        tick();
        rd_p[0] = 0;
        for (int i = 1; i <= 10; i++) begin
            #1;
            if (reply[0]) begin
                nrep++;
                rep_i = i;
            end
            if (ld_valid[0] && ld_ready[0]) acc_i = i;
            tick();
            if (acc_i == i) ld_valid[0] = 0;
        end
        ld_valid[0] = 0;
        ref_mem0[b] = x;
        last_rd[0] = ref_mem0[5];
        n_run++;
        if (nrep !== 1 || rep_i !== 3 || rdata[0] !== ref_mem0[5]) begin
            n_fail++;
            $display("FAIL ld_cpu_first: got n=%0d at=%0d d=%h want 1 3 %h",
                     nrep, rep_i, rdata[0], ref_mem0[5]);
        end
        n_run++;
        if (acc_i !== 4) begin
            n_fail++;
            $display("FAIL ld_accept: got cycle %0d want 4", acc_i);
        end
        nrep = 0;
        acc_i = -1;
        ld_valid[0] = 1;
        ld_write[0] = 0;
        ld_addr[0] = b;
        for (int i = 0; i <= 8; i++) begin
            #1;
            if (ld_valid[0] && ld_ready[0]) acc_i = i;
            if (ld_rvalid[0]) begin
                nrv++;
                rv_i = i;
                rv_d = ld_rdata[0];
            end
            if (reply[0]) nrep++;
            tick();
            if (acc_i == i) ld_valid[0] = 0;
        end
        ld_valid[0] = 0;
        n_run++;
        if (acc_i !== 0 || nrv !== 1 || rv_i !== 3 || rv_d !== x || nrep !== 0) begin
            n_fail++;
            $display("FAIL ld_read: got acc=%0d nrv=%0d at=%0d d=%h nrep=%0d want 0 1 3 %h 0",
                     acc_i, nrv, rv_i, rv_d, nrep, x);
        end
    endtask

    task automatic test_reset_mid();
        int lat, nrep;
        int nbad = 0;
        logic [30:0] r;
        cpu_access(0, 0, 1, 10'h010, 31'h7, 6, 0, lat, nrep, r);
        ref_mem0[16] = 31'h7;
        rd_p[0] = 0;
        wr_p[0] = 1;
        addr[0] = 10'h010;
        wdata[0] = 31'h123;
        tick();
        wr_p[0] = 0;
        resetn = 0;
        tick();
        resetn = 1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (reply[0]) nbad++;
            tick();
        end
        n_run++;
        if (nbad !== 0 || rdata[0] !== 31'd0) begin
            n_fail++;
            $display("FAIL rst_mid_reply: got n=%0d rd=%h want 0 0", nbad, rdata[0]);
        end
        cpu_access(0, 1, 0, 10'h010, 31'h0, 6, 0, lat, nrep, r);
        last_rd[0] = 31'h7;
        n_run++;
        if (r !== 31'h7 || lat !== 3) begin
            n_fail++;
            $display("FAIL rst_mid_keep: got d=%h lat=%0d want 7 3", r, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat, nrep;
        logic [30:0] r;
        logic [9:0] a [8];
        logic [30:0] d;
        for (int n = 0; n < 8; n++) begin
            a[n] = 10'(n * 113 + $urandom_range(0, 100));
            d = 31'($urandom);
            cpu_access(1, 0, 1, a[n], d, 3, 1, lat, nrep, r);
            ref_mem1[a[n]] = d;
            n_run++;
            if (lat !== 1) begin
                n_fail++;
                $display("FAIL b2b_wr%0d: got lat=%0d want 1", n, lat);
            end
        end
        for (int n = 0; n < 8; n++) begin
            cpu_access(1, 1, 0, a[n], 31'h0, 3, 1, lat, nrep, r);
            n_run++;
            if (lat !== 1 || r !== ref_mem1[a[n]]) begin
                n_fail++;
                $display("FAIL b2b_rd%0d: got lat=%0d d=%h want 1 %h",
                         n, lat, r, ref_mem1[a[n]]);
            end
        end
        n_run++;
        if (err[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_err: got %b want 0", err[1]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_random();
        test_busy_err();
        test_rw_collision();
        test_loader();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
